// File: rtl/vmx_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// vmx_cmd_sequencer
//
// Purpose:
//   Pops 32-bit user instructions from the ISA command FIFO and expands each
//   one into a burst of read, write and execute commands for the memory access
//   and execution processors.
//
//   Every instruction runs up to two phases:
//     W phase : W_BEATS beats of weight loads (pushes rd + ex).
//     M phase : M_BEATS beats of multiplicand loads and result writes
//               (pushes rd + ex + wr).
//   When loop_mode (instr[31]) is set, the W phase is skipped because the
//   weights are already resident.
//
//   A beat only fires when every queue it writes has room. All of a beat's
//   pushes are issued in the same cycle, so a beat is never split across
//   queues.
//
// Instruction word:
//   [31]    loop_mode
//   [30:29] simd_mode
//   [28:24] reserved (ignored)
//   [23:16] wr_off
//   [15:8]  rd2_off (multiplicand)
//   [7:0]   rd1_off (weight)
//
// Ports:
//   clk               clock
//   rst               synchronous active-high reset
//   cfg_base_address  base address added to every scaled offset
//   isa_fifo_instr    instruction word, valid the cycle after isa_fifo_rena
//   isa_fifo_empty    ISA FIFO empty
//   isa_fifo_rena     ISA FIFO read enable (one-cycle pulse in FETCH)
//   rd_fifo_instr     read command address       / rd_fifo_full / rd_fifo_wren
//   wr_fifo_instr     write command address      / wr_fifo_full / wr_fifo_wren
//   ex_fifo_instr     execution opcode           / ex_fifo_full / ex_fifo_wren
//   busy              high in every state except IDLE
//
// Optional feature (macro VMX_CMD_SEQ_PERF_EN):
//   perf_instr_cnt    completed-instruction counter, saturating
//   perf_stall_cnt    ISSUE cycles without a fire, saturating
//   Without the macro, neither port nor any counter logic exists.
// -----------------------------------------------------------------------------
module vmx_cmd_sequencer #(
  parameter int ADDR_W     = 32,
  parameter int W_BEATS    = 4,
  parameter int M_BEATS    = 4,
  parameter int BEAT_BYTES = 4,
  parameter int OFF_SHIFT  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cfg_base_address,
  input  logic [31:0]       isa_fifo_instr,
  input  logic              isa_fifo_empty,
  output logic              isa_fifo_rena,
  output logic [ADDR_W-1:0] rd_fifo_instr,
  input  logic              rd_fifo_full,
  output logic              rd_fifo_wren,
  output logic [ADDR_W-1:0] wr_fifo_instr,
  input  logic              wr_fifo_full,
  output logic              wr_fifo_wren,
  output logic [31:0]       ex_fifo_instr,
  input  logic              ex_fifo_full,
  output logic              ex_fifo_wren,
  output logic              busy
`ifdef VMX_CMD_SEQ_PERF_EN
  ,
  output logic [31:0]       perf_instr_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  // Beat counter is at least 8 bits wide so k[7:0] can always be placed in
  // the execution opcode, and wide enough to reach the longer phase.
  localparam int MAX_BEATS  = (W_BEATS > M_BEATS) ? W_BEATS : M_BEATS;
  localparam int K_W        = ($clog2(MAX_BEATS) < 8) ? 8 : $clog2(MAX_BEATS);
  // BEAT_BYTES is a power of two, so k*BEAT_BYTES reduces to a shift.
  localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);

  localparam logic [K_W-1:0] LAST_W = K_W'(W_BEATS - 1);
  localparam logic [K_W-1:0] LAST_M = K_W'(M_BEATS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_LATCH = 2'd2,
    ST_ISSUE = 2'd3
  } state_t;

  typedef enum logic {
    PH_W = 1'b0,
    PH_M = 1'b1
  } phase_t;

  state_t          state_r;
  state_t          state_nxt_s;
  phase_t          phase_r;
  logic [K_W-1:0]  k_r;
  logic [31:0]     cmd_r;

  logic            fire_s;
  logic            last_w_beat_s;
  logic            instr_done_s;
  logic [7:0]      rd_off_s;
  logic [ADDR_W-1:0] beat_ofs_s;
  logic            unused_rsvd_s;

  // Reserved instruction bits are latched with the rest of the word but
  // never decoded.
  assign unused_rsvd_s = ^cmd_r[28:24];

  // Fire qualification: the write queue only matters during the M phase.
  always_comb begin
    fire_s        = 1'b0;
    last_w_beat_s = 1'b0;
    instr_done_s  = 1'b0;
    if (state_r == ST_ISSUE) begin
      fire_s = !rd_fifo_full && !ex_fifo_full &&
               ((phase_r == PH_W) || !wr_fifo_full);
    end else begin
      fire_s = 1'b0;
    end
    if (fire_s && (phase_r == PH_W) && (k_r == LAST_W)) begin
      last_w_beat_s = 1'b1;
    end else begin
      last_w_beat_s = 1'b0;
    end
    if (fire_s && (phase_r == PH_M) && (k_r == LAST_M)) begin
      instr_done_s = 1'b1;
    end else begin
      instr_done_s = 1'b0;
    end
  end

  // Next-state decode and the ISA FIFO read strobe.
  always_comb begin
    state_nxt_s   = state_r;
    isa_fifo_rena = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!isa_fifo_empty) begin
          state_nxt_s = ST_FETCH;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        isa_fifo_rena = 1'b1;
        state_nxt_s   = ST_LATCH;
      end
      ST_LATCH: begin
        state_nxt_s = ST_ISSUE;
      end
      ST_ISSUE: begin
        // Emptiness is only looked at once the last beat has gone out, so a
        // FIFO draining mid-instruction has no effect on this burst.
        if (instr_done_s) begin
          if (!isa_fifo_empty) begin
            state_nxt_s = ST_FETCH;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_ISSUE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register, instruction latch, beat counter and phase tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      phase_r <= PH_W;
      k_r     <= '0;
      cmd_r   <= 32'h0000_0000;
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        ST_LATCH: begin
          cmd_r   <= isa_fifo_instr;
          k_r     <= '0;
          phase_r <= isa_fifo_instr[31] ? PH_M : PH_W;
        end
        ST_ISSUE: begin
          if (last_w_beat_s) begin
            phase_r <= PH_M;
            k_r     <= '0;
          end else if (instr_done_s) begin
            phase_r <= PH_W;
            k_r     <= '0;
          end else if (fire_s) begin
            k_r <= k_r + K_W'(1);
          end else begin
            k_r <= k_r;
          end
        end
        default: begin
          k_r <= k_r;
        end
      endcase
    end
  end

  // Command words: combinational from state, k, phase and cmd so they stay
  // constant across any number of stall cycles.
  always_comb begin
    if (phase_r == PH_W) begin
      rd_off_s = cmd_r[7:0];
    end else begin
      rd_off_s = cmd_r[15:8];
    end
    beat_ofs_s    = ADDR_W'(k_r) << BEAT_SHIFT;
    rd_fifo_instr = cfg_base_address + (ADDR_W'(rd_off_s) << OFF_SHIFT) + beat_ofs_s;
    wr_fifo_instr = cfg_base_address + (ADDR_W'(cmd_r[23:16]) << OFF_SHIFT) + beat_ofs_s;
    ex_fifo_instr = {(phase_r == PH_W), cmd_r[31], cmd_r[30:29], 20'h0_0000, k_r[7:0]};
  end

  // Push strobes: every queue a beat touches is written in the same cycle.
  always_comb begin
    rd_fifo_wren = fire_s;
    ex_fifo_wren = fire_s;
    if (phase_r == PH_M) begin
      wr_fifo_wren = fire_s;
    end else begin
      wr_fifo_wren = 1'b0;
    end
    busy = (state_r != ST_IDLE);
  end

`ifdef VMX_CMD_SEQ_PERF_EN
  logic stall_s;

  // A stall is any ISSUE cycle in which the current beat could not fire.
  always_comb begin
    if (state_r == ST_ISSUE) begin
      stall_s = !fire_s;
    end else begin
      stall_s = 1'b0;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_instr_cnt <= 32'h0000_0000;
      perf_stall_cnt <= 32'h0000_0000;
    end else begin
      if (instr_done_s && (perf_instr_cnt != 32'hFFFF_FFFF)) begin
        perf_instr_cnt <= perf_instr_cnt + 32'd1;
      end else begin
        perf_instr_cnt <= perf_instr_cnt;
      end
      if (stall_s && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end else begin
        perf_stall_cnt <= perf_stall_cnt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vmx_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_vmx_cmd_sequencer
//
// Directed bench for vmx_cmd_sequencer with default parameters. Expected
// rd/wr/ex command words are derived from each instruction when it is placed
// in the modelled ISA FIFO and queued; they are popped and compared whenever
// the DUT pushes. Inputs change 1 time unit after the rising edge, outputs are
// sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_vmx_cmd_sequencer;

  localparam int NW = 4;
  localparam int NM = 4;
  localparam int BB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cfg_base_address;
  logic [31:0] isa_fifo_instr;
  logic        isa_fifo_empty;
  logic        isa_fifo_rena;
  logic [31:0] rd_fifo_instr;
  logic        rd_fifo_full;
  logic        rd_fifo_wren;
  logic [31:0] wr_fifo_instr;
  logic        wr_fifo_full;
  logic        wr_fifo_wren;
  logic [31:0] ex_fifo_instr;
  logic        ex_fifo_full;
  logic        ex_fifo_wren;
  logic        busy;
`ifdef VMX_CMD_SEQ_PERF_EN
  logic [31:0] perf_instr_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  vmx_cmd_sequencer dut (
    .clk              (clk),
    .rst              (rst),
    .cfg_base_address (cfg_base_address),
    .isa_fifo_instr   (isa_fifo_instr),
    .isa_fifo_empty   (isa_fifo_empty),
    .isa_fifo_rena    (isa_fifo_rena),
    .rd_fifo_instr    (rd_fifo_instr),
    .rd_fifo_full     (rd_fifo_full),
    .rd_fifo_wren     (rd_fifo_wren),
    .wr_fifo_instr    (wr_fifo_instr),
    .wr_fifo_full     (wr_fifo_full),
    .wr_fifo_wren     (wr_fifo_wren),
    .ex_fifo_instr    (ex_fifo_instr),
    .ex_fifo_full     (ex_fifo_full),
    .ex_fifo_wren     (ex_fifo_wren),
    .busy             (busy)
`ifdef VMX_CMD_SEQ_PERF_EN
    ,
    .perf_instr_cnt   (perf_instr_cnt),
    .perf_stall_cnt   (perf_stall_cnt)
`endif
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] rd_q[$];
  logic [31:0] wr_q[$];
  logic [31:0] ex_q[$];
  logic [31:0] isa_q[$];

  int n_rd, n_wr, n_ex, n_rena, n_busy;
  logic        snap_rd_wren, snap_wr_wren, snap_ex_wren;
  logic [31:0] snap_rd_instr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference expansion of one instruction into its expected command words.
  task automatic expect_instr(input logic [31:0] ins, input logic [31:0] base);
    logic [31:0] rd1, rd2, wro;
    rd1 = {24'h0, ins[7:0]};
    rd2 = {24'h0, ins[15:8]};
    wro = {24'h0, ins[23:16]};
    if (!ins[31]) begin
      for (int k = 0; k < NW; k++) begin
        rd_q.push_back(base + rd1 + 32'(k * BB));
        ex_q.push_back({1'b1, ins[31], ins[30:29], 20'h0, 8'(k)});
      end
    end
    for (int k = 0; k < NM; k++) begin
      rd_q.push_back(base + rd2 + 32'(k * BB));
      wr_q.push_back(base + wro + 32'(k * BB));
      ex_q.push_back({1'b0, ins[31], ins[30:29], 20'h0, 8'(k)});
    end
  endtask

  task automatic enqueue(input logic [31:0] ins, input logic [31:0] base);
    cfg_base_address = base;
    isa_q.push_back(ins);
    isa_fifo_empty = 1'b0;
    expect_instr(ins, base);
  endtask

  task automatic clear_counts();
    n_rd = 0; n_wr = 0; n_ex = 0; n_rena = 0; n_busy = 0;
  endtask

  // One clock: sample and score outputs on the falling edge, then model the
  // ISA FIFO read that the DUT requested.
  task automatic cyc();
    logic        fetched;
    logic [31:0] e;
    @(negedge clk);
    snap_rd_wren  = rd_fifo_wren;
    snap_wr_wren  = wr_fifo_wren;
    snap_ex_wren  = ex_fifo_wren;
    snap_rd_instr = rd_fifo_instr;
    fetched = isa_fifo_rena;
    if (isa_fifo_rena) n_rena++;
    if (busy) n_busy++;
    if (rd_fifo_wren || ex_fifo_wren) chk("rd_ex_paired", {31'h0, rd_fifo_wren}, {31'h0, ex_fifo_wren});
    if (rd_fifo_wren) begin
      n_rd++;
      if (rd_q.size() > 0) e = rd_q.pop_front(); else e = 32'hxxxx_xxxx;
      chk("rd_addr", rd_fifo_instr, e);
    end
    if (wr_fifo_wren) begin
      n_wr++;
      if (wr_q.size() > 0) e = wr_q.pop_front(); else e = 32'hxxxx_xxxx;
      chk("wr_addr", wr_fifo_instr, e);
    end
    if (ex_fifo_wren) begin
      n_ex++;
      if (ex_q.size() > 0) e = ex_q.pop_front(); else e = 32'hxxxx_xxxx;
      chk("ex_op", ex_fifo_instr, e);
    end
    @(posedge clk);
    #1;
    if (fetched) begin
      if (isa_q.size() > 0) isa_fifo_instr = isa_q.pop_front();
      isa_fifo_empty = (isa_q.size() == 0);
    end
  endtask

  task automatic run_until(input int target, input int budget);
    int n;
    n = 0;
    while ((n_rd < target) && (n < budget)) begin
      cyc();
      n++;
    end
    chk("rd_push_count", n_rd, target);
  endtask

  task automatic drained();
    chk("rd_q_drained", rd_q.size(), 0);
    chk("wr_q_drained", wr_q.size(), 0);
    chk("ex_q_drained", ex_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    cfg_base_address = 32'h1000_0000;
    isa_fifo_instr = 32'h0;
    isa_fifo_empty = 1'b1;
    rd_fifo_full = 1'b0;
    wr_fifo_full = 1'b0;
    ex_fifo_full = 1'b0;
    clear_counts();
    for (int i = 0; i < 3; i++) cyc();
    rst = 1'b0;
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_rena", {31'h0, isa_fifo_rena}, 32'h0);
    chk("rst_rd_wren", {31'h0, rd_fifo_wren}, 32'h0);
    chk("rst_wr_wren", {31'h0, wr_fifo_wren}, 32'h0);
    chk("rst_ex_wren", {31'h0, ex_fifo_wren}, 32'h0);

    // Basic W+M burst, no backpressure.
    clear_counts();
    enqueue(32'h0030_2010, 32'h1000_0000);
    run_until(8, 100);
    chk("t1_busy_low", {31'h0, busy}, 32'h0);
    chk("t1_wr_count", n_wr, 4);
    chk("t1_busy_cycles", n_busy, 10);
    chk("t1_rena", n_rena, 1);
    cyc();
    drained();

    // Loop mode: M phase only.
    clear_counts();
    enqueue(32'h8030_2010, 32'h1000_0000);
    run_until(4, 100);
    chk("t2_busy_low", {31'h0, busy}, 32'h0);
    chk("t2_wr_count", n_wr, 4);
    chk("t2_busy_cycles", n_busy, 6);
    cyc();
    drained();

    // Read queue full for 3 cycles at beat 2.
    clear_counts();
    enqueue(32'h0030_2010, 32'h1000_0000);
    run_until(2, 100);
    rd_fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t3_stall_rd_wren", {31'h0, snap_rd_wren}, 32'h0);
      chk("t3_stall_ex_wren", {31'h0, snap_ex_wren}, 32'h0);
      chk("t3_stall_rd_stable", snap_rd_instr, 32'h1000_0018);
    end
    rd_fifo_full = 1'b0;
    run_until(8, 100);
    chk("t3_busy_cycles", n_busy, 13);
    cyc();
    drained();
`ifdef VMX_CMD_SEQ_PERF_EN
    chk("t3_perf_stall", perf_stall_cnt, 32'd3);
    chk("t3_perf_instr", perf_instr_cnt, 32'd3);
`endif

    // Write queue full: W phase unaffected, M beat 0 stalls.
    clear_counts();
    wr_fifo_full = 1'b1;
    enqueue(32'h0030_2010, 32'h1000_0000);
    run_until(4, 100);
    chk("t4_w_no_stall", n_busy, 6);
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("t4_stall_rd_wren", {31'h0, snap_rd_wren}, 32'h0);
      chk("t4_stall_wr_wren", {31'h0, snap_wr_wren}, 32'h0);
    end
    wr_fifo_full = 1'b0;
    run_until(8, 100);
    chk("t4_busy_cycles", n_busy, 12);
    cyc();
    drained();

    // Two instructions back to back.
    clear_counts();
    enqueue(32'h0030_2010, 32'h1000_0000);
    enqueue(32'h2055_4433, 32'h1000_0000);
    run_until(16, 200);
    chk("t5_rena", n_rena, 2);
    chk("t5_busy_cycles", n_busy, 20);
    chk("t5_wr_count", n_wr, 8);
    cyc();
    drained();

    // Address wrap past all-ones.
    clear_counts();
    enqueue(32'h0000_0004, 32'hFFFF_FFF8);
    run_until(8, 100);
    cyc();
    drained();

    // Reset during beat 5 abandons the instruction.
    clear_counts();
    enqueue(32'h0030_2010, 32'h1000_0000);
    run_until(5, 100);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t7_rst_pushes", n_rd, 6);
    chk("t7_busy", {31'h0, busy}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t7_no_rd", {31'h0, snap_rd_wren}, 32'h0);
      chk("t7_no_wr", {31'h0, snap_wr_wren}, 32'h0);
    end
    chk("t7_no_refetch", n_rena, 1);
    chk("t7_rd_left", rd_q.size(), 2);
    chk("t7_wr_left", wr_q.size(), 2);
    rd_q.delete();
    wr_q.delete();
    ex_q.delete();
    clear_counts();
    enqueue(32'h0030_2010, 32'h2000_0000);
    run_until(8, 100);
    cyc();
    drained();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
